// File: rtl/uart_tx_framer_pkg.sv
// Shared types for the UART transmit framer: FSM state encoding, line levels
// and the per-frame configuration latched at launch.
package uart_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic two_stop;
  } frame_cfg_t;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Pop handshake between the first-word-fall-through TX FIFO and the framer.
interface uart_tx_framer_if;

  logic [7:0] data;
  logic       data_available;
  logic       req;

  modport master (output data, output data_available, input req);
  modport slave  (input data, input data_available, output req);

endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit PHY: pops a byte from the TX FIFO and frames it as start,
// LSB-first data, optional parity and 1 or 2 stop bits, one bit per baud tick.
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_clk_posedge,
  uart_tx_framer_if.slave  fifo,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  output logic             busy,
  output logic             tx
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_e            state;
  tx_state_e            state_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  frame_cfg_t           cfg;
  logic                 par;
  logic                 tick;
  logic                 last_bit;
  logic                 last_stop;
  logic                 launch;

  assign tick     = tx_clk_posedge;
  assign last_bit = (bit_cnt == LAST_BIT);
  // The stop period ending now is the final one unless a second stop bit is still owed.
  assign last_stop = (state == ST_STOP) && !(cfg.two_stop && !stop_cnt);
  assign launch    = tick && fifo.data_available && ((state == ST_IDLE) || last_stop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaulting every combinational output first keeps all paths assigned,
    // so no latch is inferred.
    state_nxt = state;
    if (launch) begin
      state_nxt = ST_START;
    end else if (tick) begin
      case (state)
        ST_START:  state_nxt = ST_DATA;
        ST_DATA:   if (last_bit) state_nxt = cfg.parity_en ? ST_PARITY : ST_STOP;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   if (last_stop) state_nxt = ST_IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    fifo.req = launch;
    busy     = (state != ST_IDLE);
  end

  // Datapath: shift register, counters, latched config and the registered line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= IDLE_LVL;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      cfg      <= '0;
      par      <= 1'b0;
    end else if (launch) begin
      shift <= fifo.data[DATA_BITS-1:0];
      cfg   <= frame_cfg_t'{parity_en, parity_odd, two_stop};
      par   <= (^fifo.data[DATA_BITS-1:0]) ^ parity_odd;
      tx    <= START_LVL;
    end else if (tick) begin
      case (state)
        ST_START: begin
          tx      <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= '0;
        end
        ST_DATA: begin
          if (!last_bit) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else begin
            tx       <= cfg.parity_en ? par : IDLE_LVL;
            stop_cnt <= 1'b0;
          end
        end
        ST_PARITY: begin
          tx       <= IDLE_LVL;
          stop_cnt <= 1'b0;
        end
        ST_STOP: begin
          tx       <= IDLE_LVL;
          stop_cnt <= 1'b1;
        end
        default: tx <= IDLE_LVL;
      endcase
    end
  end

endmodule
